// File: rtl/lct_l1a_match.sv
// rtl/lct_l1a_match.sv - LCT history with L1A latency-window matching and event counters.
module lct_l1a_match #(
    parameter int DLY   = 128,
    parameter int WIN   = 3,
    parameter int CNT_W = 24
) (
    input  logic             CMSCLK,
    input  logic             SYS_RST,
    input  logic             LCT,
    input  logic             L1A,
    input  logic             CLR_CNT,
    output logic             L1A_MATCH,
    output logic             NO_MATCH,
    output logic [CNT_W-1:0] L1A_CNT,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [CNT_W-1:0] EVT_NUM
);

    localparam int HALF = (WIN - 1) / 2;
    // An LCT sampled d edges before the L1A edge sits at h[d-1] before the shift.
    localparam int LO   = DLY - HALF - 1;
    localparam int HI   = DLY + HALF - 1;
    localparam int HLEN = HI + 1;

    logic [HLEN-1:0]  h;
    logic [HLEN-1:0]  h_next;
    logic [HLEN-1:0]  oldest;
    logic             hit;
    logic [CNT_W-1:0] l1a_base;
    logic [CNT_W-1:0] match_base;
    logic [CNT_W-1:0] evt_base;

    always_comb begin
        hit    = 1'b0;
        oldest = '0;
        for (int k = LO; k <= HI; k++) begin
            if (h[k]) begin
                hit    = 1'b1;
                oldest = HLEN'(1) << k;
            end
        end
    end

    // Clearing the consumed bit before the shift is the same as clearing k+1 after it.
    always_comb begin
        h_next = {h[HLEN-2:0], LCT};
        if (L1A) begin
            h_next = {h[HLEN-2:0] & ~oldest[HLEN-2:0], LCT};
        end
    end

    always_comb begin
        l1a_base   = CLR_CNT ? '0 : L1A_CNT;
        match_base = CLR_CNT ? '0 : MATCH_CNT;
        evt_base   = CLR_CNT ? '0 : EVT_NUM;
    end

    always_ff @(posedge CMSCLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            h         <= '0;
            L1A_MATCH <= 1'b0;
            NO_MATCH  <= 1'b0;
            L1A_CNT   <= '0;
            MATCH_CNT <= '0;
            EVT_NUM   <= '0;
        end else begin
            h         <= h_next;
            L1A_MATCH <= L1A & hit;
            NO_MATCH  <= L1A & ~hit;
            if (L1A) begin
                L1A_CNT <= l1a_base + CNT_W'(1);
                if (hit) begin
                    MATCH_CNT <= match_base + CNT_W'(1);
                    EVT_NUM   <= l1a_base + CNT_W'(1);
                end else begin
                    MATCH_CNT <= match_base;
                    EVT_NUM   <= evt_base;
                end
            end else begin
                L1A_CNT   <= l1a_base;
                MATCH_CNT <= match_base;
                EVT_NUM   <= evt_base;
            end
        end
    end

endmodule

// File: doc/lct_l1a_match.md
# lct_l1a_match

Trigger-receive matcher for the DCFEB. It sits behind the backplane trigger inputs, the same LCT/L1A stream the trigger simulator top produces in simulation. It keeps a per-crossing history of LCT pulses and, for every L1A, decides whether an LCT fell inside the programmed latency window. It issues a one-cycle match or no-match strobe plus running L1A, match and event-number counts to the readout logic.

## Interface
- DLY, 128: nominal LCT-to-L1A latency in CMSCLK cycles; legal 8..248.
- WIN, 3: window width in cycles; odd, legal 1..15; window is DLY-(WIN-1)/2 .. DLY+(WIN-1)/2.
- CNT_W, 24: width of all counters.

- CMSCLK  in  1  40 MHz bunch-crossing clock; all logic on rising edge.
- SYS_RST  in  1  asynchronous, active-high reset.
- LCT  in  1  LCT pulse, one per crossing it is asserted.
- L1A  in  1  L1A pulse, one per crossing it is asserted.
- CLR_CNT  in  1  synchronous counter clear.
- L1A_MATCH  out  1  one-cycle strobe: L1A found an LCT in window.
- NO_MATCH  out  1  one-cycle strobe: L1A found no LCT in window.
- L1A_CNT  out  CNT_W  number of L1As seen, wraps.
- MATCH_CNT  out  CNT_W  number of matched L1As, wraps.
- EVT_NUM  out  CNT_W  L1A_CNT value of the most recent matched L1A.

## Operation
- History register H[0..255], shifted every cycle. After edge t, H[k] holds LCT sampled k cycles before edge t; H[0] = LCT at edge t.
- At an edge where L1A=1, the matcher evaluates hit = OR of H[k] over the window, using history contents before that edge's shift.
- Consumption on hit: the set bit with the largest k in the window is cleared. Because the clear applies at the same edge as the shift, it lands at position k+1. An LCT matches at most one L1A.
- A simultaneous LCT and L1A do not interact. DLY ≥ 8 keeps H[0] out of the window.
- Back-to-back L1As, one per cycle, are each evaluated independently and see earlier consumptions.
- L1A_CNT increments on every L1A. MATCH_CNT increments on every hit. Both wrap modulo 2^CNT_W.
- EVT_NUM loads the post-increment L1A_CNT on a hit and holds otherwise.
- CLR_CNT zeroes L1A_CNT, MATCH_CNT and EVT_NUM. If CLR_CNT coincides with an L1A, the clear applies first, then the increment: the L1A counts as 1, and on a hit EVT_NUM = 1 and MATCH_CNT = 1.
- SYS_RST clears H, all counters and both strobes. LCTs seen before reset can never match.
- There is no state machine beyond the history, counters and output registers. All outputs are registered.

## Timing
- Reset values: L1A_MATCH=0, NO_MATCH=0, L1A_CNT=0, MATCH_CNT=0, EVT_NUM=0, H all zeros.
- Latency: an L1A sampled at edge t drives exactly one of L1A_MATCH or NO_MATCH high for the cycle following edge t, that is, valid after edge t+1 is not the case; it is valid from edge t until edge t+1.
- Counters and EVT_NUM update at the same edge as the strobe and are coherent with it.
- L1A_MATCH and NO_MATCH are never high together. Both are low in any cycle following an edge with L1A=0.
- Reset asserted mid-window: strobes drop asynchronously. The first L1A after deassertion sees an empty history.
- The window-evaluation critical path is an OR of at most 15 bits plus a priority-select of the oldest set bit. It must close at 40 MHz with a single register stage.

## Test plan
All scenarios use DLY=128 and WIN=3, so the window is k=127..129. Cycle numbers count edges after SYS_RST deasserts.

- LCT at 100, L1A at 228 (k=128) -> L1A_MATCH high after edge 228 for one cycle; L1A_CNT=1, MATCH_CNT=1, EVT_NUM=1.
- LCT at 100, L1A at 230 (k=130) -> NO_MATCH for one cycle; L1A_CNT=1, MATCH_CNT=0, EVT_NUM=0.
- One LCT at 100, L1As at 227 and 229 -> first L1A gives L1A_MATCH; second gives NO_MATCH (consumed); MATCH_CNT=1, L1A_CNT=2.
- LCTs at 100 and 101, L1As at 229 and 230 -> both give L1A_MATCH (first consumes LCT 100, second matches LCT 101 at k=129); MATCH_CNT=2, EVT_NUM=2.
- LCT at 100, SYS_RST pulse at 150, L1A at 228 -> NO_MATCH; strobes and counters read 0 during reset.
- CNT_W=4 with 16 unmatched L1As -> L1A_CNT wraps to 0. Then CLR_CNT coincident with an in-window L1A -> L1A_CNT=1, MATCH_CNT=1, EVT_NUM=1.
